debug_mem_sequencer: RTL and testbench
======================================

# debug_mem_sequencer

- Synthesizable successor to the bench-only BRAM load/run/dump flow.
- Sits between a host streaming interface and the RV32ICore debug ports (`CPU_Debug_*Cache_A2/WD2/WE2/RD2`), generalised to `NCH` memory channels.
- One start command performs three phases while owning the core reset:
  - **Load**: streams images into each channel's BRAM.
  - **Run**: releases the core for a fixed cycle budget.
  - **Dump**: streams every word of every channel back out with its address.

## Interface

**Parameters**

- `NCH`, 2: number of memory channels (channel 0 = data cache, channel 1 = instruction cache).
- `WORDS`, 4096: 32-bit words per channel.
- `RUN_CYCLES`, 200000: number of cycles the core runs out of reset.
- `RD_LATENCY`, 1: BRAM debug-port read latency in cycles (≥1).

**Ports**

- `CPU_CLK` in 1: single clock.
- `CPU_RST` in 1: synchronous, active-high reset.
- `Start` in 1: one-cycle command pulse. Accepted only in IDLE or DONE.
- `Mode` in 2: sampled on `Start`.
  - bit0 = skip load.
  - bit1 = skip dump.
- `LD_Valid` in 1: load word valid.
- `LD_Ready` out 1: load word ready.
- `LD_Data` in 32: load word.
- `LD_Last` in 1: marks the final word of the current channel's image.
- `DP_Valid` out 1: dump word valid.
- `DP_Ready` in 1: dump word ready.
- `DP_Data` out 32: dumped word.
- `DP_Addr` out 32: byte address of the dumped word.
- `DP_Chan` out `$clog2(NCH)` (min 1): channel of the dumped word.
- `DBG_A2` out `NCH*32`: per-channel debug address (channel c in bits `[32c+31:32c]`).
- `DBG_WD2` out 32: write data, shared by all channels.
- `DBG_WE2` out `NCH*4`: per-channel byte enables.
- `DBG_RD2` in `NCH*32`: per-channel read data.
- `CORE_RST` out 1: reset to the core.
- `Busy` out 1: sequence in progress.
- `Done` out 1: sequence complete.

## Operation

**States:** IDLE, LOAD, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, DONE.

**IDLE / DONE**

- `CORE_RST`=1.
- On `Start`, the next state depends on `Mode`:
  - bit0=0 → LOAD, channel index `ch`=0, word index `idx`=0.
  - bit0=1, bit1=0 → RUN.
  - bit0=1, bit1=1 → RUN; after RUN, go to DONE.
- `Start` while `Busy` is ignored.

**LOAD**

- `CORE_RST`=1 and `LD_Ready`=1.
- Each handshake writes `LD_Data` to channel `ch` at byte address `4*idx`, then increments `idx`.
- The channel ends on whichever comes first:
  - a handshake with `LD_Last`=1;
  - the handshake with `idx`=`WORDS-1`.
- At channel end: `ch`++ and `idx`=0.
- Words not written keep their previous BRAM contents; there is no zero-fill.
- After channel `NCH-1` ends → RUN.

**RUN**

- `CORE_RST`=0 for exactly `RUN_CYCLES` cycles, tracked by a down-counter.
- When the count reaches 0:
  - go to DUMP_ADDR with `ch`=0, `idx`=0 if `Mode`[1]=0;
  - otherwise go to DONE.

**Dump phase**

- `CORE_RST`=1 throughout; the core is frozen.
- DUMP_ADDR: drives `DBG_A2[ch]`=`4*idx` → DUMP_WAIT.
- DUMP_WAIT: waits `RD_LATENCY` cycles, then captures `DBG_RD2[ch]` into `DP_Data` → DUMP_OUT.
- DUMP_OUT: `DP_Valid`=1 until `DP_Ready`.
  - On the handshake: advance `idx`.
  - On wrap at `WORDS`: advance `ch`.
  - After the final word of channel `NCH-1` → DONE; otherwise → DUMP_ADDR.

**Arithmetic**

- `idx` is `$clog2(WORDS+1)` bits wide.
- Addresses are `{idx,2'b00}` zero-extended to 32 bits.
- The run counter is `$clog2(RUN_CYCLES+1)` bits wide.

**Reset**

- `CPU_RST` at any cycle, including mid-LOAD, RUN or DUMP, returns the block to IDLE next edge with all reset values applied.
- Partial BRAM writes already performed stay in the BRAMs.

## Timing

**Reset values**

- `CORE_RST`=1.
- `LD_Ready`=0, `DP_Valid`=0, `Busy`=0, `Done`=0.
- `DBG_WE2`=0, `DBG_A2`=0, `DBG_WD2`=0.
- `DP_Data`=0, `DP_Addr`=0, `DP_Chan`=0.

**Load**

- All debug outputs are registered.
- A handshake at edge k produces, during the cycle after k:
  - `DBG_WE2` channel slice = 4'b1111, all other channels 0;
  - `DBG_A2` and `DBG_WD2` set to the written address and data.
- `DBG_WE2` returns to 0 on the following edge if no handshake occurred.
- Throughput: one word per cycle.

**Start and status**

- `LD_Ready` rises the cycle after `Start` is accepted.
- `Busy`=1 from the cycle after `Start` until DONE is entered.
- `Done`=1 in DONE; cleared by `Start` or reset.

**Run**

- The first cycle of RUN has `CORE_RST`=0.
- `CORE_RST` returns to 1 on the edge that leaves RUN.

**Dump**

- The address→valid latency per word is `RD_LATENCY`+1 cycles after DUMP_ADDR.
- `DP_Data`, `DP_Addr` and `DP_Chan` are held stable while `DP_Valid`=1 and `DP_Ready`=0.
- Peak throughput: one word per `RD_LATENCY`+2 cycles.

## Test plan

- **Full flow**:
  - Stimulus: `NCH`=2, `WORDS`=8, `RUN_CYCLES`=10. Load ch0 = 0x100..0x107, and ch1 = 3 words 0xA,0xB,0xC with `LD_Last` on 0xC.
  - Response: exactly 11 writes with `DBG_A2` 0..0x1C then 0..0x8; `CORE_RST` low for exactly 10 cycles; dump emits 16 words.
  - Memory model without a core: ch0 reads back 0x100..0x107; ch1 words 3..7 are unchanged from preload.
- **Dump backpressure**: `DP_Ready` toggling 1-of-3 cycles → no word lost or duplicated; `DP_Data` stable across stalls.
- **Mode**: `Mode`=2'b01 → `LD_Ready` never asserted and `DBG_WE2` stays 0. `Mode`=2'b11 → no `DP_Valid`; `Done` asserts on the edge after RUN ends.
- **Reset mid-RUN**: `CPU_RST` after 4 run cycles → next cycle `CORE_RST`=1, `Busy`=0, state IDLE. A new `Start` restarts from ch0 idx0.
- **Ignored start**:
  - `Start` during LOAD → no effect.
  - Load without `LD_Last` on ch0 → channel ends after word `WORDS-1` (addr 0x1C); the next word goes to ch1 addr 0.

Source files
------------

// File: rtl/debug_mem_sequencer_if.sv
// debug_mem_sequencer_if: host load/dump streams, status and per-channel BRAM debug-port bundle
interface debug_mem_sequencer_if #(
  parameter int NCH = 2
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  logic              Start;
  logic [1:0]        Mode;
  logic              LD_Valid;
  logic              LD_Ready;
  logic [31:0]       LD_Data;
  logic              LD_Last;
  logic              DP_Valid;
  logic              DP_Ready;
  logic [31:0]       DP_Data;
  logic [31:0]       DP_Addr;
  logic [CW-1:0]     DP_Chan;
  logic [NCH*32-1:0] DBG_A2;
  logic [31:0]       DBG_WD2;
  logic [NCH*4-1:0]  DBG_WE2;
  logic [NCH*32-1:0] DBG_RD2;
  logic              CORE_RST;
  logic              Busy;
  logic              Done;
  modport slave (
    input  Start, Mode, LD_Valid, LD_Data, LD_Last, DP_Ready, DBG_RD2,
    output LD_Ready, DP_Valid, DP_Data, DP_Addr, DP_Chan, DBG_A2, DBG_WD2, DBG_WE2,
    output CORE_RST, Busy, Done
  );
  modport master (
    output Start, Mode, LD_Valid, LD_Data, LD_Last, DP_Ready, DBG_RD2,
    input  LD_Ready, DP_Valid, DP_Data, DP_Addr, DP_Chan, DBG_A2, DBG_WD2, DBG_WE2,
    input  CORE_RST, Busy, Done
  );
endinterface

// File: rtl/debug_mem_sequencer.sv
// debug_mem_sequencer: load images into core BRAMs, run the core for a fixed budget, dump BRAMs
module debug_mem_sequencer #(
  parameter int NCH        = 2,
  parameter int WORDS      = 4096,
  parameter int RUN_CYCLES = 200000,
  parameter int RD_LATENCY = 1
) (
  input logic CPU_CLK,
  input logic CPU_RST,
  debug_mem_sequencer_if.slave bus
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int IW = $clog2(WORDS + 1);
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam int LW = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  localparam logic [RW-1:0] RUN_INIT = RW'(RUN_CYCLES - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(RD_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, DONE} state_t;
  state_t               r_state;
  logic [CW-1:0]        r_ch;
  logic [IW-1:0]        r_idx;
  logic [RW-1:0]        r_cnt;
  logic [LW-1:0]        r_lat;
  logic                 r_skip_dump;
  logic [NCH-1:0][31:0] r_a2;
  logic [NCH-1:0][3:0]  r_we;
  logic [31:0]          r_wd;
  logic [31:0]          r_dp_data;
  logic [31:0]          r_dp_addr;
  logic [CW-1:0]        r_dp_chan;
  logic                 r_ld_ready;
  logic                 r_dp_valid;
  logic                 r_core_rst;
  logic                 r_busy;
  logic                 r_done;
  logic [NCH-1:0][31:0] w_rd;
  logic [31:0]          w_addr;
  logic [31:0]          w_next_addr;
  logic                 w_ld_hs;
  logic                 w_ld_end;
  logic                 w_idx_end;
  logic                 w_ch_end;
  assign w_rd        = bus.DBG_RD2;
  assign w_addr      = 32'({r_idx, 2'b00});
  assign w_next_addr = 32'({r_idx + IW'(1), 2'b00});
  assign w_idx_end   = r_idx == LAST_IDX;
  assign w_ch_end    = r_ch == LAST_CH;
  assign w_ld_hs     = r_ld_ready && bus.LD_Valid;
  assign w_ld_end    = bus.LD_Last || w_idx_end;
  // The next dump address is registered on entry to DUMP_ADDR so the BRAM sees it during that cycle
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      r_state     <= IDLE;
      r_ch        <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_skip_dump <= 1'b0;
      r_a2        <= '0;
      r_we        <= '0;
      r_wd        <= '0;
      r_dp_data   <= '0;
      r_dp_addr   <= '0;
      r_dp_chan   <= '0;
      r_ld_ready  <= 1'b0;
      r_dp_valid  <= 1'b0;
      r_core_rst  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_we <= '0;
      case (r_state)
        IDLE, DONE: if (bus.Start) begin
          r_busy      <= 1'b1;
          r_done      <= 1'b0;
          r_skip_dump <= bus.Mode[1];
          r_ch        <= '0;
          r_idx       <= '0;
          if (bus.Mode[0]) begin
            r_state    <= RUN;
            r_core_rst <= 1'b0;
            r_cnt      <= RUN_INIT;
          end else begin
            r_state    <= LOAD;
            r_ld_ready <= 1'b1;
          end
        end
        LOAD: if (w_ld_hs) begin
          r_we[r_ch] <= 4'hF;
          r_a2[r_ch] <= w_addr;
          r_wd       <= bus.LD_Data;
          r_idx      <= w_ld_end ? '0 : r_idx + 1'b1;
          if (w_ld_end) r_ch <= r_ch + 1'b1;
          if (w_ld_end && w_ch_end) begin
            r_state    <= RUN;
            r_ld_ready <= 1'b0;
            r_core_rst <= 1'b0;
            r_cnt      <= RUN_INIT;
          end
        end
        RUN: if (r_cnt == '0) begin
          r_core_rst <= 1'b1;
          r_ch       <= '0;
          r_idx      <= '0;
          if (r_skip_dump) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= DUMP_ADDR;
            r_a2[0] <= '0;
          end
        end else r_cnt <= r_cnt - 1'b1;
        DUMP_ADDR: begin
          r_state <= DUMP_WAIT;
          r_lat   <= LAT_INIT;
        end
        DUMP_WAIT: if (r_lat == '0) begin
          r_state    <= DUMP_OUT;
          r_dp_valid <= 1'b1;
          r_dp_data  <= w_rd[r_ch];
          r_dp_addr  <= w_addr;
          r_dp_chan  <= r_ch;
        end else r_lat <= r_lat - 1'b1;
        DUMP_OUT: if (bus.DP_Ready) begin
          r_dp_valid <= 1'b0;
          r_idx      <= w_idx_end ? '0 : r_idx + 1'b1;
          if (w_idx_end) r_ch <= r_ch + 1'b1;
          if (w_idx_end && w_ch_end) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= DUMP_ADDR;
            r_a2[w_idx_end ? r_ch + 1'b1 : r_ch] <= w_idx_end ? '0 : w_next_addr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.LD_Ready = r_ld_ready;
  assign bus.DP_Valid = r_dp_valid;
  assign bus.DP_Data  = r_dp_data;
  assign bus.DP_Addr  = r_dp_addr;
  assign bus.DP_Chan  = r_dp_chan;
  assign bus.DBG_A2   = r_a2;
  assign bus.DBG_WD2  = r_wd;
  assign bus.DBG_WE2  = r_we;
  assign bus.CORE_RST = r_core_rst;
  assign bus.Busy     = r_busy;
  assign bus.Done     = r_done;
endmodule

// File: tb/tb_debug_mem_sequencer.sv
// tb_debug_mem_sequencer: table-driven sequences with write/dump scoreboards against a BRAM model
module tb_debug_mem_sequencer;
  localparam int NCH = 2;
  localparam int WORDS = 8;
  logic clk = 1'b0;
  logic rst;
  logic preload;
  logic bp_en;
  int cyc = 0;
  always #5 clk = ~clk;
  debug_mem_sequencer_if #(.NCH(NCH)) bus ();
  debug_mem_sequencer #(.NCH(NCH), .WORDS(WORDS), .RUN_CYCLES(10), .RD_LATENCY(1)) dut (
    .CPU_CLK(clk),
    .CPU_RST(rst),
    .bus(bus)
  );
  typedef struct { int ch; logic [31:0] addr; logic [31:0] data; } rec_t;
  typedef struct {
    logic [1:0] mode; int n0; bit last0; int n1; bit bp; bit ign; int exp_wr; int exp_dump;
  } vec_t;
  rec_t wq[$];
  rec_t dq[$];
  rec_t w;
  vec_t vt[6];
  logic [31:0] mem [NCH][WORDS];
  logic [31:0] ref_mem [NCH][WORDS];
  logic [NCH*32-1:0] rd;
  logic [7:0] we_exp;
  int n_chk = 0, n_pass = 0;
  int n_wr, n_run, n_ldr, n_dump, n_lo;
  function automatic logic [31:0] pat(input int c, input int i);
    return 32'hC0DE_0000 | 32'(c * 256 + i);
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  always @(posedge clk)
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < WORDS; i++) if (preload) mem[c][i] <= pat(c, i);
      for (int b = 0; b < 4; b++)
        if (!preload && bus.DBG_WE2[4*c+b]) mem[c][bus.DBG_A2[32*c+2 +: 3]][8*b +: 8] <= bus.DBG_WD2[8*b +: 8];
      rd[32*c +: 32] <= mem[c][bus.DBG_A2[32*c+2 +: 3]];
    end
  assign bus.DBG_RD2 = rd;
  initial begin
    bus.DP_Ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.DP_Ready = bp_en ? (cyc % 3 == 0) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (!bus.CORE_RST) n_run++;
    if (bus.LD_Ready) n_ldr++;
    if (|bus.DBG_WE2) begin
      n_wr++;
      if (wq.size() == 0) chk("wr_unexpected", 64'(bus.DBG_WE2), 64'd0);
      else begin
        w = wq.pop_front();
        we_exp = 8'(8'h0F << (4 * w.ch));
        chk("wr_we", 64'(bus.DBG_WE2), 64'(we_exp));
        chk("wr_addr", 64'(bus.DBG_A2[32*w.ch +: 32]), 64'(w.addr));
        chk("wr_data", 64'(bus.DBG_WD2), 64'(w.data));
      end
    end
    if (bus.DP_Valid) begin
      if (dq.size() == 0) chk("dp_unexpected", 64'(bus.DP_Valid), 64'd0);
      else begin
        chk("dp_data", 64'(bus.DP_Data), 64'(dq[0].data));
        chk("dp_addr", 64'(bus.DP_Addr), 64'(dq[0].addr));
        chk("dp_chan", 64'(bus.DP_Chan), 64'(dq[0].ch));
        if (bus.DP_Ready) begin
          void'(dq.pop_front());
          n_dump++;
        end
      end
    end
  end
  task automatic start_seq(input logic [1:0] m);
    @(posedge clk);
    #1 bus.Mode = m;
    bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    n_wr = 0; n_run = 0; n_ldr = 0; n_dump = 0;
    chk("start_busy", 64'(bus.Busy), 64'd1);
    chk("start_done_clr", 64'(bus.Done), 64'd0);
    chk("start_ld_ready", 64'(bus.LD_Ready), 64'(!m[0]));
    chk("start_core_rst", 64'(bus.CORE_RST), 64'(!m[0]));
  endtask
  task automatic load_words(input int n0, input bit last0, input int n1, input logic [31:0] base, input bit ign);
    for (int c = 0; c < NCH; c++) begin
      int n;
      n = (c == 0) ? n0 : n1;
      for (int i = 0; i < n; i++) begin
        logic [31:0] d;
        d = base + ((c == 0) ? 32'h100 : 32'hA) + 32'(i);
        wq.push_back('{c, 32'(4 * i), d});
        ref_mem[c][i] = d;
        bus.LD_Valid = 1'b1;
        bus.LD_Data = d;
        bus.LD_Last = (i == n - 1) && (c == 1 || last0);
        if (ign && c == 0 && i == 3) begin
          bus.Start = 1'b1;
          bus.Mode = 2'b11;
        end
        for (int k = 0; k < 20 && !bus.LD_Ready; k++) begin
          @(posedge clk);
          #1;
        end
        chk("ld_ready", 64'(bus.LD_Ready), 64'd1);
        @(posedge clk);
        #1 bus.Start = 1'b0;
      end
    end
    bus.LD_Valid = 1'b0;
    bus.LD_Last = 1'b0;
  endtask
  task automatic run_row(input vec_t v, input int r);
    bp_en = v.bp;
    start_seq(v.mode);
    if (!v.mode[0]) load_words(v.n0, v.last0, v.n1, 32'(r) << 12, v.ign);
    if (!v.mode[1])
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < WORDS; i++) dq.push_back('{c, 32'(4 * i), ref_mem[c][i]});
    for (int k = 0; k < 400 && !bus.Done; k++) @(negedge clk);
    chk("done", 64'(bus.Done), 64'd1);
    chk("busy_end", 64'(bus.Busy), 64'd0);
    chk("core_rst_end", 64'(bus.CORE_RST), 64'd1);
    chk("n_writes", 64'(n_wr), 64'(v.exp_wr));
    chk("n_ld_ready", 64'(n_ldr), 64'(v.exp_wr));
    chk("n_run", 64'(n_run), 64'd10);
    chk("n_dump", 64'(n_dump), 64'(v.exp_dump));
    chk("wr_left", 64'(wq.size()), 64'd0);
    chk("dp_left", 64'(dq.size()), 64'd0);
  endtask
  initial begin
    rst = 1'b1; preload = 1'b1; bp_en = 1'b0;
    bus.Start = 1'b0; bus.Mode = 2'b00; bus.LD_Valid = 1'b0; bus.LD_Data = '0; bus.LD_Last = 1'b0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < WORDS; i++) ref_mem[c][i] = pat(c, i);
    vt[0] = '{2'b00, 8, 1'b1, 3, 1'b0, 1'b0, 11, 16};
    vt[1] = '{2'b00, 8, 1'b0, 2, 1'b1, 1'b1, 10, 16};
    vt[2] = '{2'b01, 0, 1'b0, 0, 1'b1, 1'b0, 0, 16};
    vt[3] = '{2'b11, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0};
    vt[4] = '{2'b10, 2, 1'b1, 1, 1'b0, 1'b0, 3, 0};
    vt[5] = '{2'b00, 1, 1'b1, 1, 1'b1, 1'b0, 2, 16};
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst_core_rst", 64'(bus.CORE_RST), 64'd1);
    chk("rst_ld_ready", 64'(bus.LD_Ready), 64'd0);
    chk("rst_dp_valid", 64'(bus.DP_Valid), 64'd0);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_dbg", {bus.DBG_WE2, bus.DBG_A2[31:0], 24'd0}, 64'd0);
    chk("rst_dbg_hi", {bus.DBG_A2[63:32], bus.DBG_WD2}, 64'd0);
    chk("rst_dp", {bus.DP_Data, bus.DP_Addr[30:0], bus.DP_Chan}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int r = 0; r < 6; r++) run_row(vt[r], r);
    bp_en = 1'b0;
    start_seq(2'b11);
    n_lo = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.CORE_RST) break;
      n_lo++;
    end
    chk("m11_run_len", 64'(n_lo), 64'd10);
    chk("m11_done_at_exit", 64'(bus.Done), 64'd1);
    chk("m11_no_dump", 64'(n_dump), 64'd0);
    start_seq(2'b00);
    load_words(1, 1'b1, 1, 32'h7000, 1'b0);
    n_lo = 0;
    for (int k = 0; k < 50 && n_lo < 4; k++) begin
      @(negedge clk);
      if (!bus.CORE_RST) n_lo++;
    end
    chk("mid_run_cycles", 64'(n_lo), 64'd4);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_core_rst", 64'(bus.CORE_RST), 64'd1);
    chk("mid_rst_busy", 64'(bus.Busy), 64'd0);
    chk("mid_rst_done", 64'(bus.Done), 64'd0);
    chk("mid_rst_ld_ready", 64'(bus.LD_Ready), 64'd0);
    chk("mid_rst_wq", 64'(wq.size()), 64'd0);
    run_row(vt[0], 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
